// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : 8N1 asynchronous serial receiver. The line is oversampled
//            (OVERSAMPLE ticks per bit), each bit is sampled at its centre,
//            and good bytes go into a first-word-fall-through FIFO.
// Ports    : clk, rst_n      - system clock, asynchronous active-low reset
//            rx_in           - serial line, asynchronous, idles high
//            rd_strobe       - pop the FIFO head (ignored when empty)
//            data_out        - FIFO head, valid while empty is 0
//            empty, full     - FIFO status
//            frame_err       - sticky: bad stop bit (or parity mismatch)
//            overrun         - sticky: good byte dropped, FIFO full
//            clear_err       - one-cycle pulse, clears both sticky flags
// Option   : `define UART_RX_PARITY_EN adds an even-parity bit after the data.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
   parameter int CLOCK_FREQ = 16000000,
   parameter int BAUD       = 9600,
   parameter int OVERSAMPLE = 16,
   parameter int WIDTH      = 8,
   parameter int LENGTH     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             rx_in,
   input  logic             rd_strobe,
   output logic [WIDTH-1:0] data_out,
   output logic             empty,
   output logic             full,
   output logic             frame_err,
   output logic             overrun,
   input  logic             clear_err
);

   localparam int c_div_raw = CLOCK_FREQ / (BAUD * OVERSAMPLE);
   localparam int c_div     = (c_div_raw < 1) ? 1 : c_div_raw;
   localparam int c_sw      = $clog2(OVERSAMPLE);
   localparam int c_bw      = $clog2(WIDTH + 1);
   localparam int c_aw      = $clog2(LENGTH);

   localparam logic [c_sw-1:0] c_samp_mid  = c_sw'(OVERSAMPLE / 2 - 1);
   localparam logic [c_sw-1:0] c_samp_last = c_sw'(OVERSAMPLE - 1);
   localparam logic [c_bw-1:0] c_bit_last  = c_bw'(WIDTH - 1);

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {
      S_WAIT_HIGH = 3'd0,
      S_IDLE      = 3'd1,
      S_START     = 3'd2,
      S_DATA      = 3'd3,
      S_STOP      = 3'd4,
      S_PARITY    = 3'd5
   } state_t;
`else
   typedef enum logic [2:0] {
      S_WAIT_HIGH = 3'd0,
      S_IDLE      = 3'd1,
      S_START     = 3'd2,
      S_DATA      = 3'd3,
      S_STOP      = 3'd4
   } state_t;
`endif

   // ------------------------------------------------------------------------
   // Input synchronizer (resets to the idle level so reset never looks like
   // a start bit)
   // ------------------------------------------------------------------------
   logic [1:0] sync_q;
   logic       rx_s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], rx_in};
      end
   end

   assign rx_s = sync_q[1];

   // ------------------------------------------------------------------------
   // Oversampling tick generator (free-running)
   // ------------------------------------------------------------------------
   logic w_tick;

   generate
      if (c_div == 1) begin : g_tick_every
         assign w_tick = 1'b1;
      end else begin : g_tick_div
         localparam int c_dw = $clog2(c_div);
         localparam logic [c_dw-1:0] c_div_last = c_dw'(c_div - 1);
         logic [c_dw-1:0] div_cnt_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               div_cnt_q <= '0;
            end else if (div_cnt_q == c_div_last) begin
               div_cnt_q <= '0;
            end else begin
               div_cnt_q <= div_cnt_q + 1'b1;
            end
         end

         assign w_tick = (div_cnt_q == c_div_last);
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Receive FSM
   // ------------------------------------------------------------------------
   state_t           state_q;
   logic [c_sw-1:0]  samp_cnt_q;
   logic [c_bw-1:0]  bit_cnt_q;
   logic [WIDTH-1:0] shift_q;
   logic             push_q;
   logic             frame_err_q;
   logic             w_par_ok;

`ifdef UART_RX_PARITY_EN
   logic parity_q;
   // Even parity: data bits plus parity bit must XOR to zero.
   assign w_par_ok = ~(^shift_q ^ parity_q);
`else
   assign w_par_ok = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_WAIT_HIGH;
         samp_cnt_q  <= '0;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         push_q      <= 1'b0;
         frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_q    <= 1'b0;
`endif
      end else begin
         push_q <= 1'b0;
         // Clear first so that a set later in this block wins.
         if (clear_err) begin
            frame_err_q <= 1'b0;
         end
         case (state_q)
            S_WAIT_HIGH: begin
               if (rx_s) begin
                  state_q <= S_IDLE;
               end
            end
            S_IDLE: begin
               if (!rx_s) begin
                  samp_cnt_q <= '0;
                  state_q    <= S_START;
               end
            end
            S_START: begin
               if (w_tick) begin
                  if (samp_cnt_q == c_samp_mid) begin
                     if (!rx_s) begin
                        samp_cnt_q <= '0;
                        bit_cnt_q  <= '0;
                        state_q    <= S_DATA;
                     end else begin
                        state_q <= S_IDLE;
                     end
                  end else begin
                     samp_cnt_q <= samp_cnt_q + 1'b1;
                  end
               end
            end
            S_DATA: begin
               if (w_tick) begin
                  if (samp_cnt_q == c_samp_last) begin
                     samp_cnt_q <= '0;
                     // LSB arrives first, so shift in from the top.
                     shift_q    <= {rx_s, shift_q[WIDTH-1:1]};
                     bit_cnt_q  <= bit_cnt_q + 1'b1;
                     if (bit_cnt_q == c_bit_last) begin
`ifdef UART_RX_PARITY_EN
                        state_q <= S_PARITY;
`else
                        state_q <= S_STOP;
`endif
                     end
                  end else begin
                     samp_cnt_q <= samp_cnt_q + 1'b1;
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
               if (w_tick) begin
                  if (samp_cnt_q == c_samp_last) begin
                     samp_cnt_q <= '0;
                     parity_q   <= rx_s;
                     state_q    <= S_STOP;
                  end else begin
                     samp_cnt_q <= samp_cnt_q + 1'b1;
                  end
               end
            end
`endif
            S_STOP: begin
               if (w_tick) begin
                  if (samp_cnt_q == c_samp_last) begin
                     samp_cnt_q <= '0;
                     if (!rx_s) begin
                        // Low stop bit (or break): wait for idle before re-arming.
                        frame_err_q <= 1'b1;
                        state_q     <= S_WAIT_HIGH;
                     end else if (!w_par_ok) begin
                        frame_err_q <= 1'b1;
                        state_q     <= S_IDLE;
                     end else begin
                        push_q  <= 1'b1;
                        state_q <= S_IDLE;
                     end
                  end else begin
                     samp_cnt_q <= samp_cnt_q + 1'b1;
                  end
               end
            end
            default: begin
               state_q <= S_WAIT_HIGH;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // FIFO. shift_q is stable while push_q is high (the FSM is back in IDLE
   // and cannot shift again for at least a bit time), so it is the write data.
   // ------------------------------------------------------------------------
   logic [WIDTH-1:0] mem_q [LENGTH];
   logic [c_aw:0]    wr_ptr_q;
   logic [c_aw:0]    rd_ptr_q;
   logic             overrun_q;
   logic             w_empty;
   logic             w_full;
   logic             w_pop;
   logic             w_wr;

   assign w_empty = (wr_ptr_q == rd_ptr_q);
   assign w_full  = (wr_ptr_q[c_aw-1:0] == rd_ptr_q[c_aw-1:0]) &&
                    (wr_ptr_q[c_aw] != rd_ptr_q[c_aw]);
   assign w_pop   = rd_strobe && !w_empty;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign w_wr    = push_q && (!w_full || w_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         overrun_q <= 1'b0;
      end else begin
         if (w_wr) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (w_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         if (clear_err) begin
            overrun_q <= 1'b0;
         end
         if (push_q && !w_wr) begin
            overrun_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr) begin
         mem_q[wr_ptr_q[c_aw-1:0]] <= shift_q;
      end
   end

   // Gate the head with empty so the output reads 0 after reset.
   assign data_out  = w_empty ? '0 : mem_q[rd_ptr_q[c_aw-1:0]];
   assign empty     = w_empty;
   assign full      = w_full;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Directed self-checking bench for uart_rx at DIV = 1
//            (16 clocks per bit, 160 clocks per frame).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

   logic       clk       = 1'b0;
   logic       rst_n     = 1'b0;
   logic       rx_in     = 1'b1;
   logic       rd_strobe = 1'b0;
   logic       clear_err = 1'b0;
   logic [7:0] data_out;
   logic       empty;
   logic       full;
   logic       frame_err;
   logic       overrun;

   int total = 0;
   int bad   = 0;
   int lat   = -1;
   int tmp   = 0;
   logic [9:0] pf;

   always #5 clk = ~clk;

   uart_rx #(
      .CLOCK_FREQ(16000000),
      .BAUD      (1000000),
      .OVERSAMPLE(16),
      .WIDTH     (8),
      .LENGTH    (16)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rx_in    (rx_in),
      .rd_strobe(rd_strobe),
      .data_out (data_out),
      .empty    (empty),
      .full     (full),
      .frame_err(frame_err),
      .overrun  (overrun),
      .clear_err(clear_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Advance n cycles; inputs change and outputs are sampled 1 time unit
   // after the rising edge.
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pop();
      rd_strobe = 1'b1;
      cyc(1);
      rd_strobe = 1'b0;
   endtask

   // Drive one 160-cycle frame. pop_at selects the cycle in which rd_strobe
   // is high (-1: never). l returns the first cycle index after which empty
   // was seen low (-1: never). The line is left at the stop-bit level.
   task automatic send_frame(input logic [7:0] b, input logic stop_hi,
                             input int pop_at, output int l);
      logic [9:0] fr;
      fr = {stop_hi, b, 1'b0};
      l  = -1;
      for (int c = 0; c < 160; c++) begin
         rx_in     = fr[c/16];
         rd_strobe = (c == pop_at);
         cyc(1);
         if (l < 0 && empty === 1'b0) l = c;
      end
      rd_strobe = 1'b0;
   endtask

   initial begin
      // ---------------- reset state ----------------
      rst_n = 1'b0;
      cyc(3);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_frame_err", 32'(frame_err), 32'd0);
      chk("rst_overrun", 32'(overrun), 32'd0);
      chk("rst_data", 32'(data_out), 32'h0);
      rst_n = 1'b1;
      cyc(3);

      // ---------------- single byte 0x48 ----------------
      send_frame(8'h48, 1'b1, -1, lat);
      chk("h_latency_in_range", 32'(lat >= 150 && lat <= 165), 32'd1);
      chk("h_empty", 32'(empty), 32'd0);
      chk("h_data", 32'(data_out), 32'h48);
      chk("h_frame_err", 32'(frame_err), 32'd0);
      pop();
      chk("h_empty_after_pop", 32'(empty), 32'd1);

      // ---------------- 4-cycle glitch, then 0xA5 ----------------
      rx_in = 1'b0;
      cyc(4);
      rx_in = 1'b1;
      cyc(40);
      chk("glitch_empty", 32'(empty), 32'd1);
      chk("glitch_frame_err", 32'(frame_err), 32'd0);
      send_frame(8'hA5, 1'b1, -1, tmp);
      chk("a5_data", 32'(data_out), 32'hA5);
      pop();
      chk("a5_empty_after_pop", 32'(empty), 32'd1);

      // ---------------- bad stop bit ----------------
      send_frame(8'h55, 1'b0, -1, tmp);
      cyc(32);
      rx_in = 1'b1;
      cyc(20);
      chk("ferr_set", 32'(frame_err), 32'd1);
      chk("ferr_empty", 32'(empty), 32'd1);
      chk("ferr_overrun", 32'(overrun), 32'd0);
      clear_err = 1'b1;
      cyc(1);
      clear_err = 1'b0;
      chk("ferr_cleared", 32'(frame_err), 32'd0);

      // ---------------- 17 bytes, no reads ----------------
      for (int i = 0; i < 17; i++) begin
         send_frame(8'(i), 1'b1, -1, tmp);
         if (i == 15) begin
            chk("fill16_full", 32'(full), 32'd1);
            chk("fill16_overrun", 32'(overrun), 32'd0);
         end
      end
      chk("fill17_overrun", 32'(overrun), 32'd1);
      chk("fill17_full", 32'(full), 32'd1);
      for (int i = 0; i < 16; i++) begin
         chk("fill_read", 32'(data_out), 32'(i));
         pop();
      end
      chk("fill_drained_empty", 32'(empty), 32'd1);
      chk("fill_drained_full", 32'(full), 32'd0);
      clear_err = 1'b1;
      cyc(1);
      clear_err = 1'b0;
      chk("overrun_cleared", 32'(overrun), 32'd0);

      // ---------------- full FIFO, pop coincides with 17th push ----------------
      for (int i = 0; i < 16; i++) begin
         send_frame(8'(i), 1'b1, -1, tmp);
      end
      send_frame(8'h10, 1'b1, lat, tmp);
      chk("samecyc_overrun", 32'(overrun), 32'd0);
      chk("samecyc_full", 32'(full), 32'd1);
      for (int i = 1; i <= 16; i++) begin
         chk("samecyc_read", 32'(data_out), 32'(i));
         pop();
      end
      chk("samecyc_empty", 32'(empty), 32'd1);

      // ---------------- reset during bit 3 ----------------
      send_frame(8'h33, 1'b1, -1, tmp);
      send_frame(8'h55, 1'b0, -1, tmp);
      cyc(32);
      rx_in = 1'b1;
      cyc(20);
      chk("prerst_frame_err", 32'(frame_err), 32'd1);
      chk("prerst_data", 32'(data_out), 32'h33);
      pf = {1'b1, 8'hC3, 1'b0};
      for (int c = 0; c < 56; c++) begin
         rx_in = pf[c/16];
         cyc(1);
      end
      rst_n = 1'b0;
      rx_in = 1'b1;
      cyc(3);
      chk("midrst_empty", 32'(empty), 32'd1);
      chk("midrst_full", 32'(full), 32'd0);
      chk("midrst_frame_err", 32'(frame_err), 32'd0);
      chk("midrst_overrun", 32'(overrun), 32'd0);
      chk("midrst_data", 32'(data_out), 32'h0);
      rst_n = 1'b1;
      cyc(5);
      chk("postrst_idle_empty", 32'(empty), 32'd1);
      send_frame(8'h9C, 1'b1, -1, tmp);
      chk("postrst_data", 32'(data_out), 32'h9C);
      chk("postrst_frame_err", 32'(frame_err), 32'd0);
      pop();
      chk("postrst_empty", 32'(empty), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
